vga_plot_sink: RTL
==================

# vga_plot_sink

Pixel-stream consumer for the drawing blocks. Accepts one (x, y, colour) pixel per cycle over a valid/ready handshake, buffers it in a small FIFO, clips pixels outside the 320x240 screen, and drives the VGA adapter write port with a one-cycle plot strobe. It sits between the display generators (connection/process/transaction drawers) and the VGA adapter. It also reports pixel statistics and end-of-drawing.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- COLOUR_W, 3, colour width in bits
- clk  in  1  system clock; all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  producer presents a pixel
- in_ready  out  1  sink can accept a pixel this cycle
- in_x  in  9  pixel x, 0..319 valid
- in_y  in  8  pixel y, 0..239 valid
- in_colour  in  COLOUR_W  pixel colour
- in_last  in  1  pixel is the final one of a drawing
- stall  in  1  adapter busy; no pixel leaves the FIFO while high
- clear  in  1  zero both statistics counters
- vga_x  out  9  x to the adapter
- vga_y  out  8  y to the adapter
- vga_colour  out  COLOUR_W  colour to the adapter
- vga_plot  out  1  write strobe, one cycle per plotted pixel
- plotted_count  out  17  pixels written since reset or clear; wraps at 2^17
- clipped_count  out  8  pixels discarded as off-screen; saturates at 255
- draw_done  out  1  one-cycle pulse when a last-flagged pixel leaves the FIFO

## Operation
- **Push.** A push occurs when in_valid && in_ready. It stores {x, y, colour, last} at the FIFO tail.
  - in_ready = (occupancy < DEPTH) && resetn. It is combinational from occupancy only and does not bypass a same-cycle pop.
- **Pop.** A pop occurs when occupancy > 0 && !stall. It removes the head entry.
- **Occupancy.** A push and a pop in the same cycle leave occupancy unchanged. Occupancy never exceeds DEPTH and never goes below 0.
- **On-screen check.** A popped entry is on-screen iff x < 320 && y < 240, compared at full 9- and 8-bit width.
- **On-screen pop.**
  - Next cycle: vga_x/vga_y/vga_colour are loaded with the entry and vga_plot = 1.
  - plotted_count increments.
- **Off-screen pop.**
  - Next cycle: vga_plot = 0 and vga_x/vga_y/vga_colour hold their previous values.
  - clipped_count increments unless it is already 255.
- **No pop.** vga_plot = 0 next cycle and the vga_* data outputs hold.
- **draw_done.** Asserts the cycle after a pop whose last = 1, whether or not that pixel was clipped.
- **clear.**
  - clear takes priority over increments: both counters become 0 next cycle.
  - A same-cycle pop still plots but is not counted.
  - clear does not touch FIFO contents or vga_* outputs.
- **Ordering.** Pixels are plotted in acceptance order; the FIFO never drops an accepted pixel.

## Timing
- **Reset (resetn low at a rising edge).**
  - FIFO emptied; occupancy = 0.
  - vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0.
  - plotted_count = 0, clipped_count = 0, draw_done = 0.
  - in_ready = 0 while resetn is low.
- **Reset mid-operation.** Buffered pixels are discarded and no strobe is issued for them.
- **Latency.** A pixel pushed at edge N into an empty FIFO is popped at edge N+1 if stall = 0. vga_plot is high in the cycle after edge N+1, i.e. 2 cycles from acceptance.
- **Throughput.** One pixel per cycle sustained with stall = 0 and in_valid held. in_ready stays 1 in this case because the FIFO holds ≤ 1 entry.
- **Back-pressure.** With stall held, the FIFO fills after DEPTH pushes. in_ready drops in the cycle after the DEPTH-th push and rises in the cycle after the first pop.
- **stall timing.** stall is sampled at the edge that would pop. An entry at the head when stall rises stays there; vga_plot goes low from the next cycle.
- **Register boundaries.** All outputs except in_ready are registered.

## Test plan
- **Single pixel.** Reset, then push (10, 20, 5, last = 1) once.
  - Required: vga_plot high exactly 1 cycle, 2 cycles after acceptance, with vga_x = 10, vga_y = 20, vga_colour = 5.
  - Required: draw_done pulses in the same cycle; plotted_count = 1.
- **Streaming.** Push a 32x2 line from (100, 50), last on the final pixel, stall = 0.
  - Required: 64 consecutive strobes in raster order; in_ready never low.
  - Required: plotted_count = 64; one draw_done, aligned with the 64th strobe.
- **Clipping.** Push (319, 239), (320, 0), (0, 240), (511, 255).
  - Required: one strobe at (319, 239); clipped_count = 3.
  - Then push 300 off-screen pixels: clipped_count saturates at 255.
- **Back-pressure.** Hold stall = 1, offer 6 pixels with DEPTH = 4.
  - Required: 4 accepted, then in_ready = 0.
  - Release stall: the 4 pixels plot in order on consecutive cycles, then the remaining 2 are accepted and plotted. No loss or duplication.
- **Clear collision.** Assert clear in the same cycle as an on-screen pop, with plotted_count = 7.
  - Required: the strobe still occurs; plotted_count = 0 afterwards.
- **Reset mid-stream.** Assert resetn = 0 with 3 pixels buffered.
  - Required: in_ready = 0 and no strobes during reset.
  - After release: all outputs 0, occupancy 0, and the first new push plots 2 cycles later.

Source files
------------

// File: rtl/vga_plot_sink.sv
// Pixel sink: buffers (x, y, colour, last) in a FIFO, clips off-screen pixels, strobes the VGA write port.
// Latency 2 cycles accept-to-strobe; in_ready drops while the FIFO is full or in reset; stall freezes the head.

module vga_plot_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
endmodule

module vga_plot_sink #(
  parameter int DEPTH    = 4,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          in_x,
  input  logic [7:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                in_last,
  input  logic                stall,
  input  logic                clear,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic [16:0]         plotted_count,
  output logic [7:0]          clipped_count,
  output logic                draw_done
);
  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                last;
  } pix_t;

  localparam int PW = $bits(pix_t);

  pix_t in_pix;
  pix_t head;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic on_screen;

  logic [8:0]          vga_x_q, vga_x_d;
  logic [7:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                plot_q, plot_d;
  logic                done_q, done_d;
  logic [16:0]         plotted_q, plotted_d;
  logic [7:0]          clipped_q, clipped_d;

  assign in_pix = {in_x, in_y, in_colour, in_last};

  // Ready looks only at occupancy, never at a same-cycle pop.
  assign in_ready  = !full && resetn;
  assign push      = in_valid && in_ready;
  assign pop       = !empty && !stall;
  assign on_screen = (head.x < 9'd320) && (head.y < 8'd240);

  vga_plot_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (in_pix),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    plotted_d    = plotted_q;
    clipped_d    = clipped_q;
    if (pop) begin
      done_d = head.last;
      if (on_screen) begin
        vga_x_d      = head.x;
        vga_y_d      = head.y;
        vga_colour_d = head.colour;
        plot_d       = 1'b1;
        plotted_d    = plotted_q + 17'd1;
      end else if (clipped_q != 8'hFF) begin
        clipped_d = clipped_q + 8'd1;
      end
    end
    // Clear wins over any same-cycle count; the strobe itself is unaffected.
    if (clear) begin
      plotted_d = '0;
      clipped_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      plotted_q    <= '0;
      clipped_q    <= '0;
    end else begin
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      plotted_q    <= plotted_d;
      clipped_q    <= clipped_d;
    end
  end

  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = vga_colour_q;
  assign vga_plot      = plot_q;
  assign draw_done     = done_q;
  assign plotted_count = plotted_q;
  assign clipped_count = clipped_q;
endmodule
